// File: rtl/reg_file_ctx_pkg.sv
// Shared types and defaults for the context-switching register file.
package rf_pkg;

    typedef enum logic [1:0] {
        CTX_IDLE,
        CTX_SAVE,
        CTX_RESTORE
    } ctx_state_t;

    localparam int RF_DW_DEFAULT    = 8;
    localparam int RF_NREGS_DEFAULT = 8;
    localparam int RF_NRD_DEFAULT   = 2;

endpackage

// File: rtl/reg_file_ctx_if.sv
// Read/write/context bus of reg_file_ctx; master drives requests, slave is the register file.
interface reg_file_ctx_if
    import rf_pkg::*;
#(
    parameter int DW    = RF_DW_DEFAULT,
    parameter int NREGS = RF_NREGS_DEFAULT,
    parameter int NRD   = RF_NRD_DEFAULT
);
    localparam int AW = $clog2(NREGS);

    logic [NRD*AW-1:0] rdAddr;
    logic [NRD*DW-1:0] rdData;
    logic [NRD-1:0]    rdZero;
    logic              wrEn;
    logic [AW-1:0]     wrAddr;
    logic [DW-1:0]     wrData;
    logic              wrReady;
    logic              saveReq;
    logic              restoreReq;
    logic              ctxBusy;
    logic              ctxDone;

    modport master (
        output rdAddr, wrEn, wrAddr, wrData, saveReq, restoreReq,
        input  rdData, rdZero, wrReady, ctxBusy, ctxDone
    );

    modport slave (
        input  rdAddr, wrEn, wrAddr, wrData, saveReq, restoreReq,
        output rdData, rdZero, wrReady, ctxBusy, ctxDone
    );

endinterface

// File: rtl/reg_file_ctx_seq.sv
// Save/restore sequencer: walks idx over all registers, one per cycle, then pulses done.
module rf_ctx_seq
    import rf_pkg::*;
#(
    parameter int NREGS = RF_NREGS_DEFAULT,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          save_req,
    input  logic          restore_req,
    output ctx_state_t    state,
    output logic [AW-1:0] idx,
    output logic          copy,
    output logic          done
);

    localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CTX_IDLE;
            idx   <= '0;
            done  <= 1'b0;
        end else begin
            case (state)
                CTX_IDLE: begin
                    done <= 1'b0;
                    // save has priority when both requests arrive together
                    if (save_req) begin
                        state <= CTX_SAVE;
                        idx   <= '0;
                    end else if (restore_req) begin
                        state <= CTX_RESTORE;
                        idx   <= '0;
                    end
                end
                CTX_SAVE, CTX_RESTORE: begin
                    idx <= idx + 1'b1;
                    if (idx == LAST) begin
                        state <= CTX_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= CTX_IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign copy = (state != CTX_IDLE);

endmodule

// File: rtl/reg_file_ctx.sv
// Multi-port register file with zero flags and a shadow bank for context save/restore.
// Define RF_BYPASS_EN for write-first reads; default is read-before-write.
module reg_file_ctx
    import rf_pkg::*;
#(
    parameter int DW    = RF_DW_DEFAULT,
    parameter int NREGS = RF_NREGS_DEFAULT,
    parameter int NRD   = RF_NRD_DEFAULT
) (
    input logic          CLK,
    input logic          RST_N,
    reg_file_ctx_if.slave bus
);

    localparam int AW = $clog2(NREGS);

    logic [DW-1:0]     live   [NREGS];
    logic [DW-1:0]     shadow [NREGS];
    ctx_state_t        state;
    logic [AW-1:0]     idx;
    logic              copy;
    logic              done;
    logic              wr_fire;
    logic [NRD*DW-1:0] rd_data;
    logic [NRD-1:0]    rd_zero;

    rf_ctx_seq #(.NREGS(NREGS)) u_seq (
        .clk         (CLK),
        .rst_n       (RST_N),
        .save_req    (bus.saveReq),
        .restore_req (bus.restoreReq),
        .state       (state),
        .idx         (idx),
        .copy        (copy),
        .done        (done)
    );

    assign wr_fire = bus.wrEn && (state == CTX_IDLE);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            live   <= '{default: '0};
            shadow <= '{default: '0};
        end else begin
            if (wr_fire)
                live[bus.wrAddr] <= bus.wrData;
            if (state == CTX_SAVE)
                shadow[idx] <= live[idx];
            if (state == CTX_RESTORE)
                live[idx] <= shadow[idx];
        end
    end

    always_comb begin
        rd_data = '0;
        rd_zero = '0;
        for (int unsigned p = 0; p < NRD; p++) begin
            logic [AW-1:0] addr;
            logic [DW-1:0] val;
            addr = bus.rdAddr[p*AW +: AW];
            val  = live[addr];
`ifdef RF_BYPASS_EN
            if (wr_fire && (bus.wrAddr == addr))
                val = bus.wrData;
`endif
            rd_data[p*DW +: DW] = val;
            rd_zero[p]          = (val == '0);
        end
    end

    assign bus.rdData  = rd_data;
    assign bus.rdZero  = rd_zero;
    assign bus.wrReady = (state == CTX_IDLE);
    assign bus.ctxBusy = copy;
    assign bus.ctxDone = done;

endmodule

// File: tb/tb_reg_file_ctx.sv
// Self-checking bench for reg_file_ctx: vector table for reads/writes, hand sequences for context copy.
module tb_reg_file_ctx;

    localparam int DW    = 8;
    localparam int NREGS = 8;
    localparam int NRD   = 2;

`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    reg_file_ctx_if #(.DW(DW), .NREGS(NREGS), .NRD(NRD)) bus ();

    reg_file_ctx #(.DW(DW), .NREGS(NREGS), .NRD(NRD)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [15:0] data;
        logic [1:0]  zero;
        string       nm;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        bit         wr;
        logic [2:0] wa;
        logic [7:0] wd;
        logic [2:0] ra0;
        logic [2:0] ra1;
        logic [7:0] e0;
        logic [7:0] e1;
    } vec_t;
    vec_t vt[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", nm, act, req);
        end
    endtask

    task automatic drive_read(input logic [2:0] ra0, input logic [2:0] ra1,
                              input logic [7:0] e0, input logic [7:0] e1, input string nm);
        exp_t e;
        bus.rdAddr = {ra1, ra0};
        e.data = {e1, e0};
        e.zero = {e1 == 8'h00, e0 == 8'h00};
        e.nm   = nm;
        sb.push_back(e);
    endtask

    task automatic check_read();
        exp_t e;
        #1;
        e = sb.pop_front();
        chk({e.nm, "_data"}, bus.rdData, e.data);
        chk({e.nm, "_zero"}, bus.rdZero, e.zero);
    endtask

    task automatic write_reg(input logic [2:0] a, input logic [7:0] d);
        @(negedge CLK);
        bus.wrEn = 1'b1; bus.wrAddr = a; bus.wrData = d;
        @(negedge CLK);
        bus.wrEn = 1'b0;
    endtask

    task automatic read_check(input logic [2:0] a, input logic [7:0] e, input string nm);
        @(negedge CLK);
        drive_read(a, a, e, e, nm);
        check_read();
    endtask

    // Issues a request pulse and watches busy/done for a bounded window.
    task automatic run_ctx(input bit sv, input bit rs, input bit poke, input string nm);
        int busy_n  = 0;
        int done_n  = 0;
        int done_at = -1;
        int rdy_bad = 0;
        @(negedge CLK);
        bus.saveReq = sv; bus.restoreReq = rs;
        for (int k = 1; k <= NREGS + 6; k++) begin
            @(negedge CLK);
            if (k == 1) begin bus.saveReq = 1'b0; bus.restoreReq = 1'b0; end
            if (poke && k == 2) begin bus.wrEn = 1'b1; bus.wrAddr = 3'd1; bus.wrData = 8'hEE; end
            if (poke && k == 3) bus.wrEn = 1'b0;
            #1;
            if (poke && k == 2) chk({nm, "_wrready_busy"}, bus.wrReady, 0);
            if (bus.ctxBusy) busy_n++;
            if (bus.ctxBusy && bus.wrReady) rdy_bad++;
            if (bus.ctxDone) begin
                done_n++;
                if (done_at < 0) done_at = k;
            end
        end
        chk({nm, "_busy_cycles"}, busy_n, NREGS);
        chk({nm, "_done_pulses"}, done_n, 1);
        chk({nm, "_done_latency"}, done_at, NREGS + 1);
        chk({nm, "_ready_while_busy"}, rdy_bad, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1);
    end

    initial begin
        int done_n;
        bus.rdAddr = '0; bus.wrEn = 1'b0; bus.wrAddr = '0; bus.wrData = '0;
        bus.saveReq = 1'b0; bus.restoreReq = 1'b0;

        vt[0] = '{1'b1, 3'd2, 8'hA5, 3'd2, 3'd5, BYP ? 8'hA5 : 8'h00, 8'h00};
        vt[1] = '{1'b0, 3'd0, 8'h00, 3'd2, 3'd5, 8'hA5, 8'h00};
        vt[2] = '{1'b1, 3'd4, 8'h33, 3'd2, 3'd4, 8'hA5, BYP ? 8'h33 : 8'h00};
        vt[3] = '{1'b0, 3'd0, 8'h00, 3'd4, 3'd3, 8'h33, 8'h00};
        vt[4] = '{1'b1, 3'd7, 8'h00, 3'd7, 3'd4, 8'h00, 8'h33};
        vt[5] = '{1'b1, 3'd7, 8'h80, 3'd7, 3'd7, BYP ? 8'h80 : 8'h00, BYP ? 8'h80 : 8'h00};
        vt[6] = '{1'b0, 3'd0, 8'h00, 3'd7, 3'd2, 8'h80, 8'hA5};
        vt[7] = '{1'b1, 3'd0, 8'h01, 3'd0, 3'd6, BYP ? 8'h01 : 8'h00, 8'h00};
        vt[8] = '{1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 8'h01, 8'h01};

        // Reset state
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        drive_read(3'd0, 3'd5, 8'h00, 8'h00, "reset_rd");
        check_read();
        chk("reset_wrready", bus.wrReady, 1);
        chk("reset_busy", bus.ctxBusy, 0);
        chk("reset_done", bus.ctxDone, 0);

        // Asynchronous reset mid-cycle clears a committed write immediately
        write_reg(3'd3, 8'h5A);
        read_check(3'd3, 8'h5A, "pre_reset_r3");
        @(posedge CLK);
        #2;
        RST_N = 1'b0;
        drive_read(3'd3, 3'd3, 8'h00, 8'h00, "async_reset_r3");
        check_read();
        chk("async_reset_wrready", bus.wrReady, 1);
        @(negedge CLK);
        RST_N = 1'b1;

        // Vector table: reads, writes, bypass behaviour
        for (int i = 0; i < 9; i++) begin
            @(negedge CLK);
            bus.wrEn = vt[i].wr; bus.wrAddr = vt[i].wa; bus.wrData = vt[i].wd;
            drive_read(vt[i].ra0, vt[i].ra1, vt[i].e0, vt[i].e1, $sformatf("vec%0d", i));
            check_read();
            chk($sformatf("vec%0d_wrready", i), bus.wrReady, 1);
        end
        @(negedge CLK);
        bus.wrEn = 1'b0;

        // Save, clobber, restore
        for (int i = 0; i < NREGS; i++) write_reg(3'(i), 8'h10 + 8'(i));
        run_ctx(1'b1, 1'b0, 1'b0, "save");
        for (int i = 0; i < NREGS; i++) write_reg(3'(i), 8'hFF);
        read_check(3'd5, 8'hFF, "clobber_r5");
        run_ctx(1'b0, 1'b1, 1'b0, "restore");
        for (int i = 0; i < NREGS; i++) begin
            @(negedge CLK);
            drive_read(3'(i), 3'(7 - i), 8'h10 + 8'(i), 8'h17 - 8'(i), $sformatf("restored%0d", i));
            check_read();
        end

        // Simultaneous requests take SAVE; a write during the copy is dropped
        write_reg(3'd6, 8'h66);
        run_ctx(1'b1, 1'b1, 1'b1, "collide");
        read_check(3'd1, 8'h11, "dropped_write_r1");
        read_check(3'd6, 8'h66, "collide_live_r6");
        write_reg(3'd6, 8'h00);
        run_ctx(1'b0, 1'b1, 1'b0, "restore_chk");
        read_check(3'd6, 8'h66, "collide_saved_r6");

        // Reset in the middle of RESTORE with idx == 3
        write_reg(3'd0, 8'h99);
        @(negedge CLK);
        bus.restoreReq = 1'b1;
        @(negedge CLK);
        bus.restoreReq = 1'b0;
        repeat (3) @(negedge CLK);
        #1;
        chk("midrestore_busy_before", bus.ctxBusy, 1);
        #1;
        RST_N = 1'b0;
        drive_read(3'd0, 3'd1, 8'h00, 8'h00, "midrestore_rd");
        check_read();
        chk("midrestore_busy", bus.ctxBusy, 0);
        chk("midrestore_wrready", bus.wrReady, 1);
        chk("midrestore_done", bus.ctxDone, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        done_n = 0;
        for (int k = 0; k < NREGS + 4; k++) begin
            @(negedge CLK);
            #1;
            if (bus.ctxDone) done_n++;
        end
        chk("midrestore_no_done", done_n, 0);
        write_reg(3'd2, 8'h77);
        run_ctx(1'b0, 1'b1, 1'b0, "restore_zero");
        read_check(3'd2, 8'h00, "shadow_cleared_r2");
        read_check(3'd6, 8'h00, "shadow_cleared_r6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
